// File: rtl/crc32_word_engine_pkg.sv
// Shared CRC-32 types, constants and the MSB-first byte update.
// Used by the engine, its byte lanes and the bench model.
package crc_types_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CRC_WIDTH  = 32;
  localparam int BYTE       = 8;
  localparam int DATA_BYTES = DATA_WIDTH / BYTE;

  localparam logic [CRC_WIDTH-1:0] POLY        = 32'h04C11DB7;
  localparam logic [CRC_WIDTH-1:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data_word;
    logic [DATA_BYTES-1:0] data_valid;
  } crc_word_t;

  function automatic logic [CRC_WIDTH-1:0] crc_byte_update(
    input logic [CRC_WIDTH-1:0] crc,
    input logic [BYTE-1:0]      data_byte
  );
    logic [CRC_WIDTH-1:0] c;
    c = crc ^ {data_byte, {(CRC_WIDTH-BYTE){1'b0}}};
    for (int i = 0; i < BYTE; i++) begin
      c = c[CRC_WIDTH-1] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_word_engine_if.sv
// Word stream in, CRC result out; slave side is the engine.
// o_crc_ok exists only when CRC_CHECK_EN is defined.
interface crc32_word_engine_if #(
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          s_data;
  logic [3:0]           s_keep;
  logic                 s_last;
  logic                 s_valid;
  logic                 s_ready;
  logic [31:0]          o_crc;
  logic [CNT_WIDTH-1:0] o_byte_cnt;
  logic                 o_valid;
  logic                 i_ready;
`ifdef CRC_CHECK_EN
  logic                 o_crc_ok;
`endif

  modport slave (
    input  s_data, s_keep, s_last, s_valid, i_ready,
    output s_ready, o_crc, o_byte_cnt, o_valid
`ifdef CRC_CHECK_EN
    , output o_crc_ok
`endif
  );

  modport master (
    output s_data, s_keep, s_last, s_valid, i_ready,
    input  s_ready, o_crc, o_byte_cnt, o_valid
`ifdef CRC_CHECK_EN
    , input o_crc_ok
`endif
  );
endinterface

// File: rtl/crc32_word_engine_byte_lane.sv
// crc32_byte_lane: combinational one-byte CRC-32 update.
// Ports: crc_in, data_byte -> crc_out.
module crc32_byte_lane
  import crc_types_pkg::*;
(
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic [BYTE-1:0]      data_byte,
  output logic [CRC_WIDTH-1:0] crc_out
);
  assign crc_out = crc_byte_update(crc_in, data_byte);
endmodule

// File: rtl/crc32_word_engine.sv
// Streaming CRC-32 over 32-bit words with byte-valid mask.
// Ports: i_clk, i_reset, bus (slave). Option: CRC_CHECK_EN.
module crc32_word_engine
  import crc_types_pkg::*;
#(
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF,
  parameter int          CNT_WIDTH  = 16
) (
  input logic i_clk,
  input logic i_reset,
  crc32_word_engine_if.slave bus
);

  localparam int CW1 = CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  state_t               state;
  logic [31:0]          crc_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  crc_word_t            beat;
  logic [2:0]           n_bytes;
  logic [2:0]           n_lanes;
  logic [5:0]           shamt;
  logic [31:0]          aligned;
  logic [31:0]          tap [0:4];
  logic [31:0]          crc_next;
  logic [CW1-1:0]       cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 accept;
  logic                 take;

  assign beat.data_word  = bus.s_data;
  assign beat.data_valid = bus.s_keep;

  assign n_bytes = 3'(beat.data_valid[0]) + 3'(beat.data_valid[1])
                 + 3'(beat.data_valid[2]) + 3'(beat.data_valid[3]);

  // Non-last words always run all four lanes.
  assign n_lanes = bus.s_last ? n_bytes : 3'd4;

  // Left-align the valid bytes so the chain always starts at lane 3.
  assign shamt   = {3'(3'd4 - n_lanes), 3'b000};
  assign aligned = beat.data_word << shamt;

  assign tap[0] = crc_q;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    crc32_byte_lane u_lane (
      .crc_in    (tap[g]),
      .data_byte (aligned[31-8*g -: 8]),
      .crc_out   (tap[g+1])
    );
  end

  always_comb begin
    crc_next = crc_q;
    unique case (n_lanes)
      3'd1:    crc_next = tap[1];
      3'd2:    crc_next = tap[2];
      3'd3:    crc_next = tap[3];
      3'd4:    crc_next = tap[4];
      default: crc_next = crc_q;
    endcase
  end

  assign cnt_sum  = {1'b0, cnt_q} + CW1'(n_bytes);
  assign cnt_next = cnt_sum[CNT_WIDTH] ? '1
                                       : cnt_sum[CNT_WIDTH-1:0];

  assign bus.s_ready = (state != HOLD) && !i_reset;

  assign accept = bus.s_valid && bus.s_ready;
  assign take   = bus.o_valid && bus.i_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      crc_q          <= CRC_INIT;
      cnt_q          <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_crc      <= '0;
      bus.o_byte_cnt <= '0;
`ifdef CRC_CHECK_EN
      bus.o_crc_ok   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, BUSY: begin
          if (accept) begin
            crc_q <= crc_next;
            cnt_q <= cnt_next;
            if (bus.s_last) begin
              state          <= HOLD;
              bus.o_valid    <= 1'b1;
              bus.o_crc      <= crc_next ^ CRC_XOROUT;
              bus.o_byte_cnt <= cnt_next;
`ifdef CRC_CHECK_EN
              bus.o_crc_ok   <= (crc_next == CRC_RESIDUE);
`endif
            end else begin
              state <= BUSY;
            end
          end
        end
        HOLD: begin
          if (take) begin
            state       <= IDLE;
            crc_q       <= CRC_INIT;
            cnt_q       <= '0;
            bus.o_valid <= 1'b0;
`ifdef CRC_CHECK_EN
            bus.o_crc_ok <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_word_engine.sv
// Directed and random-frame bench for crc32_word_engine.
// Residue flag checks are active when CRC_CHECK_EN is defined.
module tb_crc32_word_engine;
  import crc_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  crc32_word_engine_if bus ();

  crc32_word_engine dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d,
                      input logic [3:0]  k,
                      input logic        l);
    int n;
    n = 0;
    bus.s_data  = d;
    bus.s_keep  = k;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      chk_cnt++;
      $display("FAIL send_timeout s_ready=%b required 1",
               bus.s_ready);
    end
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.o_valid && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      chk_cnt++;
      $display("FAIL result_timeout o_valid=%b required 1",
               bus.o_valid);
    end
  endtask

  task automatic ack();
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
  endtask

  function automatic logic [31:0] model_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = crc_byte_update(c, b[i]);
    return c ^ 32'hFFFFFFFF;
  endfunction

  task automatic send_123456789();
    send(32'h31323334, 4'b1111, 1'b0);
    send(32'h35363738, 4'b1111, 1'b0);
    send(32'h00000039, 4'b0001, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    chk_cnt++;
    if (bus.s_ready !== 1'b0)
      $display("FAIL rst_s_ready got %b required 0", bus.s_ready);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_valid !== 1'b0)
      $display("FAIL rst_o_valid got %b required 0", bus.o_valid);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_crc !== 32'h0)
      $display("FAIL rst_o_crc got %h required 0", bus.o_crc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_byte_cnt !== 16'h0)
      $display("FAIL rst_cnt got %0d required 0", bus.o_byte_cnt);
    else pass_cnt++;
`ifdef CRC_CHECK_EN
    chk_cnt++;
    if (bus.o_crc_ok !== 1'b0)
      $display("FAIL rst_crc_ok got %b required 0", bus.o_crc_ok);
    else pass_cnt++;
`endif
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (bus.s_ready !== 1'b1)
      $display("FAIL post_rst_s_ready got %b required 1",
               bus.s_ready);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_check_value();
    send(32'h31323334, 4'b1111, 1'b0);
    send(32'h35363738, 4'b1111, 1'b0);
    chk_cnt++;
    if (bus.o_valid !== 1'b0)
      $display("FAIL chk_early_valid got %b required 0", bus.o_valid);
    else pass_cnt++;
    send(32'h00000039, 4'b0001, 1'b1);
    chk_cnt++;
    if (bus.o_valid !== 1'b1)
      $display("FAIL chk_latency got %b required 1", bus.o_valid);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_crc !== 32'hFC891918)
      $display("FAIL chk_crc got %h required fc891918", bus.o_crc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_byte_cnt !== 16'd9)
      $display("FAIL chk_cnt got %0d required 9", bus.o_byte_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (bus.s_ready !== 1'b0)
      $display("FAIL chk_hold_ready got %b required 0", bus.s_ready);
    else pass_cnt++;
    ack();
    chk_cnt++;
    if (bus.o_valid !== 1'b0 || bus.s_ready !== 1'b1)
      $display("FAIL chk_release valid=%b ready=%b required 0/1",
               bus.o_valid, bus.s_ready);
    else pass_cnt++;
  endtask

  task automatic test_empty_frame();
    send(32'h00000000, 4'b0000, 1'b1);
    chk_cnt++;
    if (bus.o_valid !== 1'b1)
      $display("FAIL empty_valid got %b required 1", bus.o_valid);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_crc !== 32'h00000000)
      $display("FAIL empty_crc got %h required 0", bus.o_crc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_byte_cnt !== 16'd0)
      $display("FAIL empty_cnt got %0d required 0", bus.o_byte_cnt);
    else pass_cnt++;
    ack();
  endtask

  task automatic test_backpressure();
    send_123456789();
    bus.s_data  = 32'hDEADBEEF;
    bus.s_keep  = 4'b1111;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cnt++;
      if (bus.s_ready !== 1'b0 || bus.o_valid !== 1'b1 ||
          bus.o_crc !== 32'hFC891918 || bus.o_byte_cnt !== 16'd9)
        $display("FAIL hold_c%0d rdy=%b v=%b crc=%h cnt=%0d required 0/1/fc891918/9",
                 i, bus.s_ready, bus.o_valid, bus.o_crc,
                 bus.o_byte_cnt);
      else pass_cnt++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    ack();
    bus.i_ready = 1'b1;
    send_123456789();
    chk_cnt++;
    if (bus.o_valid !== 1'b1 || bus.o_crc !== 32'hFC891918)
      $display("FAIL second_frame v=%b crc=%h required 1/fc891918",
               bus.o_valid, bus.o_crc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_byte_cnt !== 16'd9)
      $display("FAIL second_cnt got %0d required 9", bus.o_byte_cnt);
    else pass_cnt++;
    tick();
    bus.i_ready = 1'b0;
    chk_cnt++;
    if (bus.o_valid !== 1'b0)
      $display("FAIL second_taken got %b required 0", bus.o_valid);
    else pass_cnt++;
  endtask

  task automatic test_residue();
    send(32'h31323334, 4'b1111, 1'b0);
    send(32'h35363738, 4'b1111, 1'b0);
    send(32'h39FC8919, 4'b1111, 1'b0);
    send(32'h00000018, 4'b0001, 1'b1);
    wait_valid();
    chk_cnt++;
    if (bus.o_crc !== 32'h38FB2284)
      $display("FAIL residue_crc got %h required 38fb2284", bus.o_crc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_byte_cnt !== 16'd13)
      $display("FAIL residue_cnt got %0d required 13", bus.o_byte_cnt);
    else pass_cnt++;
`ifdef CRC_CHECK_EN
    chk_cnt++;
    if (bus.o_crc_ok !== 1'b1)
      $display("FAIL residue_ok got %b required 1", bus.o_crc_ok);
    else pass_cnt++;
`endif
    ack();
    send(32'h31323335, 4'b1111, 1'b0);
    send(32'h35363738, 4'b1111, 1'b0);
    send(32'h39FC8919, 4'b1111, 1'b0);
    send(32'h00000018, 4'b0001, 1'b1);
    wait_valid();
    chk_cnt++;
    if (bus.o_crc === 32'h38FB2284)
      $display("FAIL flipped_crc got %h required not 38fb2284",
               bus.o_crc);
    else pass_cnt++;
`ifdef CRC_CHECK_EN
    chk_cnt++;
    if (bus.o_crc_ok !== 1'b0)
      $display("FAIL flipped_ok got %b required 0", bus.o_crc_ok);
    else pass_cnt++;
`endif
    ack();
  endtask

  task automatic test_partial_keep();
    logic [7:0]  b7[$];
    logic [7:0]  b6[$];
    logic [31:0] e7;
    logic [31:0] e6;
    b7 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    b6 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    e7 = model_crc(b7);
    e6 = model_crc(b6);
    send(32'h31323334, 4'b1111, 1'b0);
    send(32'hAA353637, 4'b0111, 1'b1);
    wait_valid();
    chk_cnt++;
    if (bus.o_crc !== e7)
      $display("FAIL keep0111_crc got %h required %h", bus.o_crc, e7);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_byte_cnt !== 16'd7)
      $display("FAIL keep0111_cnt got %0d required 7", bus.o_byte_cnt);
    else pass_cnt++;
    ack();
    send(32'h31323334, 4'b1111, 1'b0);
    send(32'hBBCC3536, 4'b0011, 1'b1);
    wait_valid();
    chk_cnt++;
    if (bus.o_crc !== e6)
      $display("FAIL keep0011_crc got %h required %h", bus.o_crc, e6);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_byte_cnt !== 16'd6)
      $display("FAIL keep0011_cnt got %0d required 6", bus.o_byte_cnt);
    else pass_cnt++;
    ack();
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      logic [7:0]  fb[$];
      logic [31:0] exp_crc;
      logic [31:0] d;
      logic [3:0]  k;
      int          len;
      int          words;
      int          r;
      fb.delete();
      len = $urandom_range(64, 1500);
      for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
      exp_crc = model_crc(fb);
      words = (len + 3) / 4;
      for (int w = 0; w < words; w++) begin
        r = (w == words - 1) ? (len - 4 * w) : 4;
        k = (r == 4) ? 4'b1111 : (r == 3) ? 4'b0111 :
            (r == 2) ? 4'b0011 : 4'b0001;
        d = $urandom;
        for (int j = 0; j < r; j++) d[8*(r-1-j) +: 8] = fb[4*w+j];
        if ($urandom_range(0, 1) == 1) tick();
        send(d, k, w == words - 1);
      end
      wait_valid();
      chk_cnt++;
      if (bus.o_crc !== exp_crc)
        $display("FAIL rand%0d_crc got %h required %h",
                 f, bus.o_crc, exp_crc);
      else pass_cnt++;
      chk_cnt++;
      if (bus.o_byte_cnt !== 16'(len))
        $display("FAIL rand%0d_cnt got %0d required %0d",
                 f, bus.o_byte_cnt, len);
      else pass_cnt++;
      repeat ($urandom_range(0, 3)) tick();
      ack();
    end
  endtask

  task automatic test_reset_midframe();
    logic saw_valid;
    send(32'h31323334, 4'b1111, 1'b0);
    send(32'h35363738, 4'b1111, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (bus.s_ready !== 1'b0)
      $display("FAIL midrst_ready got %b required 0", bus.s_ready);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw_valid = saw_valid | bus.o_valid;
      tick();
    end
    chk_cnt++;
    if (saw_valid !== 1'b0)
      $display("FAIL midrst_valid got %b required 0", saw_valid);
    else pass_cnt++;
    send_123456789();
    wait_valid();
    chk_cnt++;
    if (bus.o_crc !== 32'hFC891918)
      $display("FAIL midrst_crc got %h required fc891918", bus.o_crc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.o_byte_cnt !== 16'd9)
      $display("FAIL midrst_cnt got %0d required 9", bus.o_byte_cnt);
    else pass_cnt++;
    ack();
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_keep  = '0;
    bus.s_last  = 1'b0;
    bus.s_valid = 1'b0;
    bus.i_ready = 1'b0;
    test_reset();
    test_check_value();
    test_empty_frame();
    test_backpressure();
    test_residue();
    test_partial_keep();
    test_random_frames();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/crc32_word_engine.md
# crc32_word_engine

Streaming CRC-32 generator that consumes 32-bit words with a per-byte valid mask, as produced by the byte-to-word packing stage, and emits one 32-bit CRC per frame. It sits directly downstream of the packer in the MAC TX/RX datapath. It supplies the FCS value for the TX framer and, optionally, a residue check for RX.

## Interface
- DATA_WIDTH, 32: input word width; only 32 is supported.
- CRC_WIDTH, 32: CRC width.
- POLY, 32'h04C11DB7: generator polynomial, processed MSB-first (non-reflected).
- CRC_INIT, 32'hFFFFFFFF: register value at the start of each frame.
- CRC_XOROUT, 32'hFFFFFFFF: value XORed into the register to form o_crc.
- CNT_WIDTH, 16: width of the frame byte counter.

Ports:
- i_clk  in  1  single clock.
- i_reset  in  1  asynchronous, active-high reset.
- s_data  in  32  data word.
- s_keep  in  4  byte-valid mask.
- s_last  in  1  final word of the frame.
- s_valid  in  1  word present.
- s_ready  out  1  engine can accept a word.
- o_crc  out  32  final CRC, equal to the register XOR CRC_XOROUT.
- o_byte_cnt  out  CNT_WIDTH  number of bytes in the frame.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts the result.
- o_crc_ok  out  1  residue match; present only with CRC_CHECK_EN.

## Operation
- Word format:
  - Legal s_keep values are 4'b1111, 4'b0111, 4'b0011, 4'b0001 and 4'b0000.
  - Valid bytes are right-aligned.
  - The first-in-time byte occupies the highest valid lane; e.g. keep 4'b0011 means byte order data[15:8] then data[7:0].
- s_keep other than 4'b1111 is legal only with s_last. On a non-last word, all lanes are processed regardless of s_keep.
- s_keep 4'b0000 with s_last closes the frame without updating the CRC.
- Per accepted word, the engine performs one to four unrolled byte updates, MSB-first, in a single cycle.
- The byte counter adds popcount(s_keep) per word and saturates at all-ones.
- FSM states:
  - IDLE: s_ready=1; the CRC register holds CRC_INIT. A beat with s_last=0 goes to BUSY; a beat with s_last=1 goes to HOLD.
  - BUSY: s_ready=1; each beat updates the CRC. A beat with s_last=1 goes to HOLD.
  - HOLD: s_ready=0 and o_valid=1; o_crc, o_byte_cnt and o_crc_ok are stable. When i_ready=1, the engine returns to IDLE and reloads CRC_INIT and count=0.
- Only one result is outstanding at a time. Input is backpressured until the result is taken.

## Timing
- Reset values:
  - s_ready=0 while i_reset is asserted, and 1 in the first cycle after deassertion.
  - o_valid=0, o_crc=0, o_byte_cnt=0, o_crc_ok=0.
  - State returns to IDLE and the CRC register to CRC_INIT.
- Beat transfer occurs on a rising edge with s_valid && s_ready.
- Latency: o_valid rises the cycle after the edge that accepts the s_last beat. The earliest next acceptance is the cycle after the o_valid && i_ready edge.
- Minimum frame turnaround is 2 cycles, giving 1 word/cycle within a frame.
- Outputs are registered; no combinational path from s_* to o_*.
- s_valid=0 mid-frame holds all state; there is no timeout.
- Reset mid-frame: the partial frame is discarded and no result is produced.

## Configuration
- CRC_CHECK_EN defined:
  - o_crc_ok is present.
  - It is set in HOLD when the raw register (before XOROUT) equals 32'hC704DD7B, which is the residue after data plus its appended MSB-first CRC.
  - It is 0 otherwise.
- CRC_CHECK_EN undefined: port and compare logic are absent; generator-only.

## Structure
- Shared package crc_types_pkg holds:
  - DATA_WIDTH, CRC_WIDTH, POLY, BYTE, DATA_BYTES, CRC_RESIDUE=32'hC704DD7B.
  - Typedef crc_word_t {data_word, data_valid}, matching s_data/s_keep.
  - Function crc_byte_update(crc, byte), shared with the bench model.
- One sub-module: crc32_byte_lane, a combinational single-byte update. Four instances are chained in the engine; s_keep selects the tap used.

## Test plan
- Frame "123456789":
  - Stimulus: words 0x31323334 keep 1111, 0x35363738 keep 1111, then 0x00000039 keep 0001 with last.
  - Response: o_crc=0xFC891918, o_byte_cnt=9, o_valid one cycle after last.
- Same frame followed by its CRC bytes FC 89 19 18 in MSB-first lanes → with CRC_CHECK_EN, o_crc_ok=1. With one data bit flipped → o_crc_ok=0.
- Single beat 0x00000000 keep 0000 with last → o_crc=0x00000000 (CRC_INIT^XOROUT), o_byte_cnt=0.
- Hold i_ready=0 for 5 cycles after the result → s_ready=0 and outputs stable throughout. A second frame sent with i_ready=1 yields the same CRC for the same data.
- Random s_valid gaps (50%) on 64–1500-byte random frames → o_crc matches the package model for every frame.
- i_reset asserted after 2 words mid-frame → no o_valid. The next full "123456789" frame gives 0xFC891918.
